// File: rtl/bch_31_pkg.sv
// bch_31_pkg: GF(2^5) constants and constant-multiplier helper for the BCH(31,21) Chien search
package bch_31_pkg;
  localparam int M = 5;
  localparam int N = 31;
  localparam logic [5:0] PRIM_POLY = 6'b100101;
  typedef logic [M-1:0] gf32_t;
  localparam gf32_t ALPHA [0:N-1] = '{
    5'd1,  5'd2,  5'd4,  5'd8,  5'd16, 5'd5,  5'd10, 5'd20,
    5'd13, 5'd26, 5'd17, 5'd7,  5'd14, 5'd28, 5'd29, 5'd31,
    5'd27, 5'd19, 5'd3,  5'd6,  5'd12, 5'd24, 5'd21, 5'd15,
    5'd30, 5'd25, 5'd23, 5'd11, 5'd22, 5'd9,  5'd18
  };
  // k is always an elaboration constant, so this folds into a fixed XOR network
  function automatic gf32_t gf32_mul_const(input gf32_t a, input int k);
    gf32_t b, x, p;
    b = ALPHA[k % N];
    x = a;
    p = '0;
    for (int j = 0; j < M; j++) begin
      if (b[j]) p = p ^ x;
      x = {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY[M-1:0] : '0);
    end
    return p;
  endfunction
endpackage

// File: rtl/bch_31_chien_cell.sv
// bch_31_chien_cell: tests whether alpha^-I is a root of 1 + lambda1*x + lambda2*x^2
module bch_31_chien_cell
  import bch_31_pkg::*;
#(
  parameter int I = 0
) (
  input  logic [4:0] lambda1,
  input  logic [4:0] lambda2,
  output logic       root_hit
);
  localparam int E1 = (N - I) % N;
  localparam int E2 = (2 * E1) % N;
  gf32_t v;
  assign v = gf32_t'(1) ^ gf32_mul_const(lambda1, E1) ^ gf32_mul_const(lambda2, E2);
  assign root_hit = (v == '0);
endmodule

// File: rtl/bch_31_chien.sv
// bch_31_chien: parallel Chien search over all 31 positions with a single registered output stage
module bch_31_chien
  import bch_31_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [4:0]  lambda1,
  input  logic [4:0]  lambda2,
  output logic        valid_out,
  output logic [30:0] error_vector,
  output logic        error_found,
  output logic [1:0]  error_count
);
  logic [N-1:0] hit;
  logic [4:0] n;
  for (genvar i = 0; i < N; i++) begin : g_cell
    bch_31_chien_cell #(.I(i)) u_cell (
      .lambda1 (lambda1),
      .lambda2 (lambda2),
      .root_hit(hit[i])
    );
  end
  assign n = 5'($countones(hit));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out    <= 1'b0;
      error_vector <= '0;
      error_found  <= 1'b0;
      error_count  <= 2'd0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        error_vector <= hit;
        error_found  <= |hit;
        error_count  <= (n >= 5'd2) ? 2'd2 : n[1:0];
      end
    end
  end
endmodule

// File: tb/tb_bch_31_chien.sv
// tb_bch_31_chien: randomized and directed checks of the Chien search against a log/antilog field model
module tb_bch_31_chien;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [4:0]  lambda1 = '0;
  logic [4:0]  lambda2 = '0;
  logic        valid_out;
  logic [30:0] error_vector;
  logic        error_found;
  logic [1:0]  error_count;

  bch_31_chien dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .lambda1     (lambda1),
    .lambda2     (lambda2),
    .valid_out   (valid_out),
    .error_vector(error_vector),
    .error_found (error_found),
    .error_count (error_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int alog [0:30];
  int lg [0:31];
  logic [30:0] e_vec = '0;
  logic        e_found = 1'b0;
  logic [1:0]  e_cnt = '0;
  logic        e_valid = 1'b0;

  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return alog[(lg[a] + lg[b]) % 31];
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Roots found by brute-force evaluation of Lambda at every alpha^-i
  task automatic model(int l1, int l2);
    int c;
    c = 0;
    for (int i = 0; i < 31; i++) begin
      int xi, v;
      xi = alog[(31 - i) % 31];
      v = 1 ^ gmul(l1, xi) ^ gmul(l2, gmul(xi, xi));
      e_vec[i] = (v == 0);
      if (v == 0) c++;
    end
    e_found = (c != 0);
    e_cnt = (c > 2) ? 2'd2 : 2'(c);
  endtask

  task automatic check_all(string tag);
    check({tag, "_valid"}, 32'(valid_out), 32'(e_valid));
    check({tag, "_vec"}, 32'(error_vector), 32'(e_vec));
    check({tag, "_found"}, 32'(error_found), 32'(e_found));
    check({tag, "_cnt"}, 32'(error_count), 32'(e_cnt));
  endtask

  task automatic step(bit v, int l1, int l2, string tag);
    valid_in = v;
    lambda1 = l1[4:0];
    lambda2 = l2[4:0];
    @(posedge clk);
    #1;
    e_valid = v;
    if (v) model(l1, l2);
    check_all(tag);
  endtask

  task automatic zero_model();
    e_vec = '0;
    e_found = 1'b0;
    e_cnt = '0;
    e_valid = 1'b0;
  endtask

  initial begin
    int x;
    x = 1;
    for (int i = 0; i < 31; i++) begin
      alog[i] = x;
      lg[x] = i;
      x = x << 1;
      if ((x & 32) != 0) x = x ^ 37;
    end
    lg[0] = 0;
    valid_in = 1'b1;
    lambda1 = 5'd25;
    lambda2 = 5'd31;
    repeat (2) @(posedge clk);
    #1;
    zero_model();
    check_all("reset");
    rst_n = 1'b1;
    step(1, 0, 0, "zero");
    check("zero_lit", 32'(error_vector), 32'h0);
    step(1, 11, 3, "irr");
    check("irr_lit", 32'(error_found), 32'h0);
    step(1, 5, 0, "one");
    check("one_lit", 32'(error_vector), 32'h0000_0020);
    step(1, 0, 12, "rep");
    check("rep_lit", 32'(error_vector), 32'h0000_0400);
    check("rep_cnt_lit", 32'(error_count), 32'd1);
    step(1, 25, 31, "two");
    check("two_lit", 32'(error_vector), 32'h0000_0180);
    check("two_cnt_lit", 32'(error_count), 32'd2);
    step(0, 7, 9, "hold1");
    step(0, 0, 0, "hold2");
    check("hold_lit", 32'(error_vector), 32'h0000_0180);
    for (int n = 0; n < 300; n++) begin
      int mode, a, b, l1, l2;
      bit v;
      v = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 2);
      a = $urandom_range(0, 30);
      b = (a + $urandom_range(1, 30)) % 31;
      if (mode == 0) begin
        l1 = $urandom_range(0, 31);
        l2 = $urandom_range(0, 31);
      end else if (mode == 1) begin
        l1 = alog[a] ^ alog[b];
        l2 = alog[(a + b) % 31];
      end else begin
        l1 = alog[a];
        l2 = 0;
      end
      step(v, l1, l2, "rand");
    end
    valid_in = 1'b1;
    lambda1 = 5'd25;
    lambda2 = 5'd31;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    zero_model();
    check_all("midrst");
    @(posedge clk);
    #1;
    check_all("inrst");
    rst_n = 1'b1;
    step(1, 5, 0, "post");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bch_31_chien.md
Name: bch_31_chien

Overview:
- Chien-search stage of the binary BCH(31,21), t=2 decoder over GF(2^5).
- Takes the error-locator polynomial Λ(x) = 1 + λ1·x + λ2·x² from the Berlekamp/PGZ stage.
- Evaluates Λ at all 31 field points α^-i in parallel and returns a registered 31-bit error-position vector plus flags.
- Feeds the syndrome-correction XOR stage.

Parameters:
- None. Field constants are fixed (see Decomposition).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  lambda1/lambda2 valid this cycle
- lambda1  input  5  Λ coefficient of x, GF(2^5) polynomial basis (bit k = coefficient of α^k)
- lambda2  input  5  Λ coefficient of x², same basis
- valid_out  output  1  error_vector/error_found/error_count valid
- error_vector  output  31  bit i = 1 iff Λ(α^-i) = 0 (error at codeword position i)
- error_found  output  1  OR-reduction of error_vector
- error_count  output  2  number of roots found (0..2)

Behaviour:
- Field: GF(2^5), primitive polynomial x^5+x^2+1 (6'b100101), α = 5'b00010.
- Per position i in 0..30, combinationally compute v_i = 1 ^ (lambda1·α^(31-i mod 31)) ^ (lambda2·α^(2(31-i) mod 31)).
  - Use constant GF multipliers (XOR networks), no general multiplier.
  - error_vector_next[i] = (v_i == 0).
- error_count_next = popcount(error_vector_next), saturating at 2 (a degree ≤2 polynomial never exceeds 2 roots).
- error_found_next = |error_vector_next.
- Outputs registered. Latency is exactly 1 cycle:
  - On the rising edge where valid_in=1, the results for that cycle's lambdas load.
  - valid_out=1 in the following cycle.
- When valid_in=0: valid_out goes 0 next cycle; error_vector, error_found and error_count hold their last values.
- Fully pipelined: a new input is accepted every cycle with no stall or back-pressure. Back-to-back valid_in produces back-to-back valid_out.
- Reset (rst_n low, asynchronous): valid_out=0, error_vector=0, error_found=0, error_count=0. Reset mid-stream discards the in-flight result.
- Degenerate inputs (must not be special-cased; they fall out of the evaluation):
  - lambda1=0, lambda2=0: Λ=1, no roots, all outputs zero.
  - lambda2=0, lambda1≠0: exactly one root, at i = log_α(lambda1).
  - lambda1=0, lambda2≠0: repeated root. Exactly one bit is set and error_count=1. The decoder treats this as uncorrectable downstream, not here.
  - Irreducible Λ: no bits set, error_found=0. This signals an uncorrectable word to the downstream stage.

Decomposition:
- Package bch_31_pkg holds:
  - M=5, N=31, PRIM_POLY=6'b100101
  - typedef gf32_t (logic [4:0])
  - the α^k exponent table (k=0..30) as a constant array
  - function gf32_mul_const (multiply by table entry, used at elaboration)
- Sub-module bch_31_chien_cell evaluates one position. It takes i as a parameter, lambda1 and lambda2 as inputs, and outputs root_hit. It is instantiated 31 times via generate.
- The top level does the popcount/OR and the output registers.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> all outputs 0 immediately (asynchronous), valid_out=0.
- lambda1=0, lambda2=12 (α^20), valid_in=1 -> next cycle error_vector=31'h0000_0400 (bit 10 only), error_found=1, error_count=1, valid_out=1.
- lambda1=11 (α^27), lambda2=3 (α^18) -> error_vector=0, error_found=0, error_count=0 (irreducible locator).
- lambda1=25 (α^25), lambda2=31 (α^15) -> error_vector=31'h0000_0180 (bits 7 and 8), error_found=1, error_count=2.
- lambda1=5 (α^5), lambda2=0 -> error_vector bit 5 only, error_count=1. Also lambda1=0, lambda2=0 -> all zero.
- Stream the cases above back-to-back with valid_in=1 every cycle, then valid_in=0 -> each result appears exactly one cycle later in order; outputs hold after valid_in drops and valid_out falls to 0.
